// File: rtl/riscv_defines.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_defines : shared constants for the instruction responder slice |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package riscv_defines;

    localparam int c_TAG_WIDTH = 4;

    typedef logic [c_TAG_WIDTH-1:0] tag_t;

endpackage
`default_nettype wire

// File: rtl/riscv_instr_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_instr_responder_if : instruction fetch request/response bus    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface riscv_instr_responder_if;
    import riscv_defines::*;

    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    tag_t        instr_rtag_o;
    logic        instr_err_o;

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_rtag_o, instr_err_o
    );

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_rtag_o, instr_err_o
    );
endinterface
`default_nettype wire

// File: rtl/riscv_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_resp_fifo : generic synchronous FIFO, non-power-of-two depths   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module riscv_resp_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rdata,
    output logic                  empty
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/riscv_instr_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_instr_responder : memory-backed instruction fetch responder    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module riscv_instr_responder
    import riscv_defines::*;
#(
    parameter int          RDATA_WIDTH = 32,
    parameter int          ADDR_WIDTH  = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 2,
    parameter int          LATENCY     = 0
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    riscv_instr_responder_if.slave      instr,
    input  wire logic                   stall_i,
    output logic                        mem_req_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    input  wire logic [RDATA_WIDTH-1:0] mem_rdata_i,
    input  wire tag_t                   mem_rtag_i
);
    localparam logic [2:0] c_DEPTH   = 3'(DEPTH);
    localparam logic [2:0] c_LATENCY = 3'(LATENCY);
    localparam int         c_ENTRY_W = RDATA_WIDTH + c_TAG_WIDTH + 1;

    logic [2:0]           r_outstanding;
    logic [2:0]           r_wait;
    logic                 r_p1_valid;
    logic                 r_p1_err;

    logic [31:0]          w_offset;
    logic [31:0]          w_word;
    logic                 w_in_window;
    logic                 w_gnt;
    logic                 w_pop;
    logic                 w_rvalid;
    logic                 w_empty;
    logic [c_ENTRY_W-1:0] w_push_entry;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_offset    = instr.instr_addr_i - BASE_ADDR;
    assign w_word      = w_offset >> 2;
    assign w_in_window = ((w_word >> ADDR_WIDTH) == '0);

    // Outputs are gated by rst_n so a reset cycle never presents a stale head.
    assign w_rvalid = rst_n & ~w_empty & (r_wait == c_LATENCY);
    assign w_pop    = w_rvalid;
    assign w_gnt    = instr.instr_req_i & ~stall_i
                    & (~rst_n | (r_outstanding < c_DEPTH) | w_pop);

    assign instr.instr_gnt_o    = w_gnt;
    assign instr.instr_rvalid_o = w_rvalid;
    assign instr.instr_rdata_o  = w_rvalid ? w_head[c_ENTRY_W-1 -: RDATA_WIDTH] : '0;
    assign instr.instr_rtag_o   = w_rvalid ? w_head[c_TAG_WIDTH:1] : '0;
    assign instr.instr_err_o    = w_rvalid ? w_head[0] : 1'b0;

    assign mem_req_o  = w_gnt & w_in_window;
    assign mem_addr_o = w_word[ADDR_WIDTH-1:0];

    // Error entries ride the same one-cycle stage so ordering and latency match hits.
    assign w_push_entry = r_p1_err ? {{(c_ENTRY_W-1){1'b0}}, 1'b1}
                                   : {mem_rdata_i, mem_rtag_i, 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_wait        <= '0;
            r_p1_valid    <= 1'b0;
            r_p1_err      <= 1'b0;
        end else begin
            r_p1_valid <= w_gnt;
            r_p1_err   <= ~w_in_window;
            case ({w_gnt, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 3'd1;
                2'b01:   r_outstanding <= r_outstanding - 3'd1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_pop) begin
                r_wait <= '0;
            end else if (!w_empty && (r_wait != c_LATENCY)) begin
                r_wait <= r_wait + 3'd1;
            end
        end
    end

    riscv_resp_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_p1_valid),
        .wdata (w_push_entry),
        .pop   (w_pop),
        .rdata (w_head),
        .empty (w_empty)
    );
endmodule
`default_nettype wire

// File: tb/tb_riscv_instr_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_riscv_instr_responder : directed vector bench for the responder   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_riscv_instr_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall0, stall1;
    logic        mreq0, mreq1;
    logic [15:0] maddr0, maddr1;
    logic [31:0] mrd0, mrd1;
    logic [3:0]  mtg0, mtg1;
    int          n_checks = 0;
    int          n_errors = 0;

    riscv_instr_responder_if bus0 ();
    riscv_instr_responder_if bus1 ();

    always #5 clk = ~clk;

    riscv_instr_responder u_dut0 (
        .clk (clk), .rst_n (rst_n), .instr (bus0.slave), .stall_i (stall0),
        .mem_req_o (mreq0), .mem_addr_o (maddr0), .mem_rdata_i (mrd0), .mem_rtag_i (mtg0)
    );

    riscv_instr_responder #(.DEPTH(2), .LATENCY(3)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .instr (bus1.slave), .stall_i (stall1),
        .mem_req_o (mreq1), .mem_addr_o (maddr1), .mem_rdata_i (mrd1), .mem_rtag_i (mtg1)
    );

    // Memory image: word k holds 4k+3, tag k[3:0]^4'hA.
    function automatic logic [31:0] mdata(input logic [15:0] a);
        return 32'(a) * 32'd4 + 32'd3;
    endfunction
    function automatic logic [3:0] mtag(input logic [15:0] a);
        return a[3:0] ^ 4'hA;
    endfunction

    always @(posedge clk) begin
        if (mreq0) begin
            mrd0 <= mdata(maddr0);
            mtg0 <= mtag(maddr0);
        end
        if (mreq1) begin
            mrd1 <= mdata(maddr1);
            mtg1 <= mtag(maddr1);
        end
    end

    typedef struct {
        logic        rst_n;
        logic        req;
        logic [31:0] addr;
        logic        stall;
        logic        gnt;
        logic        mem_req;
        logic [15:0] mem_addr;
        logic        rvalid;
        logic [31:0] rdata;
        logic [3:0]  rtag;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic q, input logic [31:0] a, input logic s,
                       input logic g, input logic m, input logic [15:0] ma,
                       input logic rv, input logic [31:0] d, input logic [3:0] t, input logic e);
        vec_t v;
        v = '{r, q, a, s, g, m, ma, rv, d, t, e};
        vecs.push_back(v);
    endtask

    task automatic idle(input logic r);
        add(r, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic resp(input logic [15:0] w);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, mdata(w), mtag(w), 1'b0);
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        int   ngrant;
        int   nresp;
        int   outst;
        logic exp_ev;
        logic [15:0] w;

        rst_n = 1'b0;
        bus0.instr_req_i = 1'b0; bus0.instr_addr_i = '0; stall0 = 1'b0;
        bus1.instr_req_i = 1'b0; bus1.instr_addr_i = '0; stall1 = 1'b0;

        // Reset, including a grant requested while reset is asserted.
        idle(1'b0);
        add(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 16'd4, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(1'b1);
        // Single fetch: word 4 -> 0x13 two cycles after grant.
        add(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 16'd4, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(1'b1);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h13, 4'hE, 1'b0);
        idle(1'b1);
        // Back-to-back burst of 8 with single-cycle throughput.
        for (int k = 0; k < 8; k++) begin
            if (k >= 2) begin
                w = 16'(k - 2);
                add(1'b1, 1'b1, 32'(4 * k), 1'b0, 1'b1, 1'b1, 16'(k), 1'b1, mdata(w), mtag(w), 1'b0);
            end else begin
                add(1'b1, 1'b1, 32'(4 * k), 1'b0, 1'b1, 1'b1, 16'(k), 1'b0, 32'h0, 4'h0, 1'b0);
            end
        end
        resp(16'd6);
        resp(16'd7);
        idle(1'b1);
        // Out-of-window fetch returns an error entry without touching memory.
        add(1'b1, 1'b1, 32'h0004_0000, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(1'b1);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h0, 4'h0, 1'b1);
        // Stall for 5 cycles with the request held; low address bits ignored.
        for (int k = 0; k < 5; k++) begin
            add(1'b1, 1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 1'b0);
        end
        add(1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 16'd8, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(1'b1);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h23, 4'h2, 1'b0);
        // Reset with two requests outstanding discards both responses.
        add(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 32'h0, 4'h0, 1'b0);
        add(1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        add(1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(1'b1);
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'hB, 4'h8, 1'b0);
        idle(1'b1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst_n            = vecs[i].rst_n;
            bus0.instr_req_i  = vecs[i].req;
            bus0.instr_addr_i = vecs[i].addr;
            stall0           = vecs[i].stall;
            @(negedge clk);
            chk("gnt",     i, 64'(bus0.instr_gnt_o),    64'(vecs[i].gnt));
            chk("mem_req", i, 64'(mreq0),               64'(vecs[i].mem_req));
            if (vecs[i].mem_req) begin
                chk("mem_addr", i, 64'(maddr0), 64'(vecs[i].mem_addr));
            end
            chk("rvalid",  i, 64'(bus0.instr_rvalid_o), 64'(vecs[i].rvalid));
            chk("rdata",   i, 64'(bus0.instr_rdata_o),  64'(vecs[i].rdata));
            chk("rtag",    i, 64'(bus0.instr_rtag_o),   64'(vecs[i].rtag));
            chk("err",     i, 64'(bus0.instr_err_o),    64'(vecs[i].err));
        end

        // Credit limit with LATENCY=3, DEPTH=2: grants at 0,1,5,9..; responses every 4 cycles.
        ngrant = 0;
        nresp  = 0;
        outst  = 0;
        for (int t = 0; t < 22; t++) begin
            @(posedge clk);
            #1;
            bus1.instr_req_i  = 1'b1;
            bus1.instr_addr_i = 32'h100 + 32'(4 * ngrant);
            @(negedge clk);
            exp_ev = (t >= 5) && (((t - 5) % 4) == 0);
            chk("c_gnt",    t, 64'(bus1.instr_gnt_o),    64'(exp_ev || t < 2));
            chk("c_rvalid", t, 64'(bus1.instr_rvalid_o), 64'(exp_ev));
            if (bus1.instr_rvalid_o) begin
                w = 16'h40 + 16'(nresp);
                chk("c_rdata", t, 64'(bus1.instr_rdata_o), 64'(mdata(w)));
                chk("c_rtag",  t, 64'(bus1.instr_rtag_o),  64'(mtag(w)));
                nresp++;
            end
            if (bus1.instr_gnt_o) begin
                ngrant++;
            end
            outst = ngrant - nresp;
            chk("c_outstanding", t, 64'(outst <= 2), 64'(1));
        end
        @(posedge clk);
        #1;
        bus1.instr_req_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
